code_display_scan: RTL and testbench

Multiplexed seven-segment display driver for the packed 28-bit digit code produced by the sequencer bank. It captures a stable snapshot of the seven 4-bit digit codes once per frame. It then scans the digits one at a time, one-hot digit select plus decoded segments, with an optional anti-ghosting blank gap. It sits between the sequencer outputs and the board's common-cathode LED digit pins, all in the `clk` domain.

---
 rtl/code_display_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 34 +++
 rtl/code_display_scan.sv | 192 +++++++++++++++++++
 tb/tb_code_display_scan.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/code_display_pkg.sv
// code_display_pkg: shared constants for the multiplexed seven-segment scanner.
// Segment patterns are ordered {g,f,e,d,c,b,a}, active-high, for a common-cathode
// display. The state encoding is shared by the scanner and any debug tap.
package code_display_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // ST_BLANK is only reachable when the blank gap is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex digit to seven-segment pattern decoder.
// Covers all sixteen codes (0-9, A, b, C, d, E, F).
module seg7_decode
  import code_display_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Pure lookup of the segment pattern for the selected digit code.
  always_comb begin
    o_seg = SEG_0;
    case (i_code)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/code_display_scan.sv
// code_display_scan: multiplexed seven-segment scanner for packed digit codes.
// The asynchronous code bus is double-registered; a snapshot is taken at each
// frame start only when both stages agree, so a frame never shows a torn value.
// Digits are lit one at a time for SCAN_DIV cycles each.
// Optional macro CODE_DISPLAY_BLANK_GAP_EN inserts BLANK_CYC dark cycles after
// every digit to suppress ghosting; without it digits switch back to back.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | scan disabled, outputs dark, digit index at 0
// ST_SHOW  | digit idx lit for SCAN_DIV cycles
// ST_BLANK | all digits dark for BLANK_CYC cycles (gap build)
module code_display_scan
  import code_display_pkg::*;
#(
  parameter int NUM_DIGITS = 7,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_code,
  input  logic                    i_en,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_dig_sel,
  output logic                    o_frame_done
);

  // One counter serves both the lit and the blank interval, sized for the longer.
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
`ifdef CODE_DISPLAY_BLANK_GAP_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] r_sync1;
  logic [4*NUM_DIGITS-1:0] r_sync2;
  logic [4*NUM_DIGITS-1:0] r_snap;
  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig_sel;
  logic                    r_frame_done;

  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_advance;
  logic                    w_frame_start;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_snap_nxt;
  logic [3:0]              w_digit;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_dig_onehot;

  // Two-stage capture of the asynchronous code bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_code;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, digit index and interval counter; disable always wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_advance     = 1'b0;
    w_frame_start = 1'b0;
    w_wrap        = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_SHOW;
          w_idx_nxt     = '0;
          w_cnt_nxt     = '0;
          w_frame_start = 1'b1;
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_cnt_nxt = '0;
`ifdef CODE_DISPLAY_BLANK_GAP_EN
            w_state_nxt = ST_BLANK;
`else
            w_advance = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
`ifdef CODE_DISPLAY_BLANK_GAP_EN
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SHOW;
            w_advance   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
`endif
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
      // Stepping past the last digit closes the frame and opens the next one.
      if (w_advance) begin
        if (r_idx == IDX_LAST) begin
          w_idx_nxt     = '0;
          w_frame_start = 1'b1;
          w_wrap        = 1'b1;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
    end
  end

  // A snapshot is accepted only if both sync stages agree at the frame start.
  assign w_snap_nxt = (w_frame_start && (r_sync1 == r_sync2)) ? r_sync2 : r_snap;

  // Select the digit that will be lit after this edge.
  always_comb begin
    w_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_digit = w_snap_nxt[4*i +: 4];
      end
    end
  end

  assign w_dig_onehot = NUM_DIGITS'(1) << w_idx_nxt;

  seg7_decode u_seg7_decode (
    .i_code (w_digit),
    .o_seg  (w_seg)
  );

  // FSM state, index, counter and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_snap  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_snap  <= w_snap_nxt;
    end
  end

  // Segments and digit select update together from the next state, so a
  // digit is lit on the same edge that enters SHOW and never shows a stale pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= '0;
      r_dig_sel    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_state_nxt == ST_SHOW) begin
        r_seg     <= w_seg;
        r_dig_sel <= w_dig_onehot;
      end else begin
        r_seg     <= '0;
        r_dig_sel <= '0;
      end
    end
  end

  assign o_seg        = r_seg;
  assign o_dig_sel    = r_dig_sel;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_code_display_scan.sv
// tb_code_display_scan: directed bench for the seven-digit scanner with
// SCAN_DIV=4, BLANK_CYC=2. Works with or without CODE_DISPLAY_BLANK_GAP_EN.
module tb_code_display_scan;

  localparam int ND = 7;
  localparam int SD = 4;
  localparam int BC = 2;
`ifdef CODE_DISPLAY_BLANK_GAP_EN
  localparam int PER = SD + BC;
`else
  localparam int PER = SD;
`endif
  localparam int FRAME = ND * PER;

  logic          clk;
  logic          rst;
  logic [27:0]   i_code;
  logic          i_en;
  logic [6:0]    o_seg;
  logic [ND-1:0] o_dig_sel;
  logic          o_frame_done;

  int total = 0;
  int bad   = 0;

  code_display_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_code       (i_code),
    .i_en         (i_en),
    .o_seg        (o_seg),
    .o_dig_sel    (o_dig_sel),
    .o_frame_done (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " seg"}, 32'(o_seg), 32'h0);
    chk({tag, " dig_sel"}, 32'(o_dig_sel), 32'h0);
    chk({tag, " frame_done"}, 32'(o_frame_done), 32'h0);
  endtask

  // Called at the negedge of frame cycle 0; returns at cycle 0 of the next frame.
  task automatic scan_frame(input string tag, input logic [27:0] exp_code, input logic fd0,
                            input int change_at, input logic [27:0] new_code);
    int d;
    int r;
    logic [6:0] es;
    logic [ND-1:0] ed;
    for (int c = 0; c < FRAME; c++) begin
      d = c / PER;
      r = c % PER;
      if (r < SD) begin
        ed = ND'(1) << d;
        es = exp_seg(exp_code[4*d +: 4]);
      end else begin
        ed = '0;
        es = '0;
      end
      chk($sformatf("%s seg c=%0d", tag, c), 32'(o_seg), 32'(es));
      chk($sformatf("%s dig_sel c=%0d", tag, c), 32'(o_dig_sel), 32'(ed));
      chk($sformatf("%s frame_done c=%0d", tag, c), 32'(o_frame_done),
          32'((c == 0) ? fd0 : 1'b0));
      if (c == change_at) i_code = new_code;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    i_en = 1'b0;
    i_code = '0;
    repeat (3) @(negedge clk);
    chk_dark("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_dark($sformatf("idle%0d", i));
    end

    // Decode and scan, then cover all sixteen codes across frames
    i_code = 28'h3B97531;
    repeat (3) @(negedge clk);
    i_en = 1'b1;
    @(negedge clk);
    chk("first dig_sel", 32'(o_dig_sel), 32'h01);
    chk("first seg", 32'(o_seg), 32'h06);
    scan_frame("frA", 28'h3B97531, 1'b0, 5, 28'h2468ACE);
    scan_frame("frB", 28'h2468ACE, 1'b1, 5, 28'hFDFDFDF);
    scan_frame("frC", 28'hFDFDFDF, 1'b1, 5, 28'h0000000);

    // Snapshot hold: change at cycle 10 only appears next frame
    scan_frame("frD", 28'h0000000, 1'b1, 10, 28'h1111111);
    scan_frame("frE", 28'h1111111, 1'b1, -1, 28'h0);

    // Unstable input around a frame start keeps the previous snapshot
    i_en = 1'b0;
    @(negedge clk);
    chk_dark("dis_before_toggle");
    for (int i = 0; i < 5; i++) begin
      i_code = i[0] ? 28'h3333333 : 28'h2222222;
      if (i == 4) i_en = 1'b1;
      @(negedge clk);
    end
    scan_frame("frUnstable", 28'h1111111, 1'b0, 0, 28'h5555555);
    scan_frame("frStable", 28'h5555555, 1'b1, -1, 28'h0);

    // Disable during digit 3
    repeat (3 * PER + 1) @(negedge clk);
    chk("d3 dig_sel", 32'(o_dig_sel), 32'h08);
    chk("d3 seg", 32'(o_seg), 32'h6D);
    i_en = 1'b0;
    i_code = 28'h1234569;
    @(negedge clk);
    chk_dark("dis_edge");
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk_dark($sformatf("dis_hold%0d", i));
    end
    i_en = 1'b1;
    @(negedge clk);
    chk("reen dig_sel", 32'(o_dig_sel), 32'h01);
    chk("reen seg", 32'(o_seg), 32'h6F);
    chk("reen frame_done", 32'(o_frame_done), 32'h0);

    // Reset during digit 5
    repeat (5 * PER) @(negedge clk);
    chk("d5 dig_sel", 32'(o_dig_sel), 32'h20);
    chk("d5 seg", 32'(o_seg), 32'h5B);
    rst = 1'b1;
    #1;
    chk_dark("rst_async");
    @(negedge clk);
    chk_dark("rst_held");
    rst = 1'b0;
    @(negedge clk);
    scan_frame("frPostRst", 28'h0000000, 1'b0, -1, 28'h0);
    scan_frame("frPostRst2", 28'h1234569, 1'b1, -1, 28'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
